// File: rtl/data_mem_arbiter_if.sv
// Request/grant/rvalid data-port bundle used by the core, the AXI adapter and data memory.
// "master" is the side that issues requests; "slave" is the side that answers them.
interface data_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (output req, addr, we, be, wdata, input  gnt, rvalid, rdata);
    modport slave  (input  req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data memory between the core (m0) and the AXI adapter (m1),
// with a hold register for stalled requests and an in-order FIFO routing responses back.
module data_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    data_mem_arbiter_if.slave  m0_io,
    data_mem_arbiter_if.slave  m1_io,
    data_mem_arbiter_if.master mem_io,
    output logic               busy_o,
    output logic               err_o
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    logic                       prio_q, prio_d;
    logic                       hold_vld_q, hold_vld_d;
    logic                       hold_id_q, hold_id_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       err_q, err_d;

    logic sel_vld, sel_id, sel_req;
    logic fifo_full, fifo_empty;
    logic mem_req, hs, pop, head_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A stalled request keeps its master selected so the memory sees stable attributes.
    always_comb begin
        sel_vld = 1'b0;
        sel_id  = 1'b0;
        if (hold_vld_q) begin
            sel_vld = 1'b1;
            sel_id  = hold_id_q;
        end else if (m0_io.req && m1_io.req) begin
            sel_vld = 1'b1;
            sel_id  = prio_q;
        end else if (m0_io.req) begin
            sel_vld = 1'b1;
            sel_id  = 1'b0;
        end else if (m1_io.req) begin
            sel_vld = 1'b1;
            sel_id  = 1'b1;
        end
    end

    assign fifo_full  = (cnt_q == MAX_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign sel_req    = sel_vld & (sel_id ? m1_io.req : m0_io.req);
    assign mem_req    = rst_ni & sel_req & ~fifo_full;
    assign hs         = mem_req & mem_io.gnt;

    assign mem_io.req   = mem_req;
    assign mem_io.addr  = !sel_vld ? '0 : (sel_id ? m1_io.addr  : m0_io.addr);
    assign mem_io.we    = !sel_vld ? '0 : (sel_id ? m1_io.we    : m0_io.we);
    assign mem_io.be    = !sel_vld ? '0 : (sel_id ? m1_io.be    : m0_io.be);
    assign mem_io.wdata = !sel_vld ? '0 : (sel_id ? m1_io.wdata : m0_io.wdata);

    assign m0_io.gnt = hs & ~sel_id;
    assign m1_io.gnt = hs &  sel_id;

    // A response with nothing outstanding is not routed anywhere; it only flags err_o.
    assign head_id      = fifo_q[rd_ptr_q];
    assign pop          = mem_io.rvalid & ~fifo_empty;
    assign m0_io.rvalid = pop & ~head_id;
    assign m1_io.rvalid = pop &  head_id;
    assign m0_io.rdata  = m0_io.rvalid ? mem_io.rdata : '0;
    assign m1_io.rdata  = m1_io.rvalid ? mem_io.rdata : '0;

    assign busy_o = rst_ni & (m0_io.req | m1_io.req | ~fifo_empty);
    assign err_o  = err_q;

    always_comb begin
        prio_d     = prio_q;
        hold_vld_d = hold_vld_q;
        hold_id_d  = hold_id_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        err_d      = err_q | (mem_io.rvalid & fifo_empty);

        if (hs) begin
            prio_d     = ~sel_id;
            hold_vld_d = 1'b0;
            fifo_d[wr_ptr_q] = sel_id;
            wr_ptr_d   = ptr_inc(wr_ptr_q);
        end else if (mem_req) begin
            hold_vld_d = 1'b1;
            hold_id_d  = sel_id;
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({hs, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q     <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_id_q  <= 1'b0;
            fifo_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            hold_vld_q <= hold_vld_d;
            hold_id_q  <= hold_id_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end
endmodule
